conv_out_packer: RTL

CONV_OUT_PACKER -- requirements
Module: conv_out_packer

---
 rtl/conv_enc_pkg.sv | 33 +++
 rtl/packer_obuf.sv | 71 +++++++
 rtl/conv_out_packer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg
// Shared definitions for the convolutional-encoder output packer:
//   - pack_state_t : packer FSM state encoding (COLLECT, EMIT0..EMIT2)
//   - STREAM_D0..2 : stream index tags carried with every output byte
//   - BYTE_W       : packed byte width
//   - OBUF_W       : output buffer entry width ({last, stream, data})
//   - emit_stream(): stream tag written by a given EMIT state
package conv_enc_pkg;

    localparam int BYTE_W      = 8;
    localparam int NUM_STREAMS = 3;
    localparam int OBUF_W      = BYTE_W + 3;

    localparam logic [1:0] STREAM_D0 = 2'd0;
    localparam logic [1:0] STREAM_D1 = 2'd1;
    localparam logic [1:0] STREAM_D2 = 2'd2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT0   = 2'd1,
        EMIT1   = 2'd2,
        EMIT2   = 2'd3
    } pack_state_t;

    function automatic logic [1:0] emit_stream(input pack_state_t s);
        case (s)
            EMIT0:   return STREAM_D0;
            EMIT1:   return STREAM_D1;
            default: return STREAM_D2;
        endcase
    endfunction

endpackage

// File: rtl/packer_obuf.sv
// packer_obuf
// Synchronous FIFO holding packed output bytes.
//   clk, reset     : clock, asynchronous active-high reset (clears pointers/count)
//   push, wr_data  : write request and entry
//   pop            : read request (head advances when not empty)
//   rd_data        : head entry, forced to zero while empty
//   full, empty    : occupancy flags
// A push on a full buffer is honoured only when a pop happens in the same
// cycle, behaving as pop-then-push with the count unchanged.
module packer_obuf #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally so out_data is valid in the same cycle
    // as out_valid; zeroed while empty so stale entries never leak out.
    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/conv_out_packer.sv
// conv_out_packer
// Packs the three 1-bit streams of a rate-1/3 encoder into bytes, LSB-first,
// and emits them stream by stream (d0, d1, d2) through an output FIFO.
//   clk, reset          : clock, asynchronous active-high reset
//   d_in[2:0], d_valid  : one coded symbol per cycle, bit i -> stream i
//   blk_last            : final symbol of a block (forces an early, zero-padded flush)
//   in_ready            : symbol accepted when d_valid && in_ready
//   out_data/out_stream : packed byte at the FIFO head and its stream index
//   out_last            : head is the stream-2 byte of a block's final flush
//   out_valid/out_ready : FIFO not empty / consumer pop
//   blk_count[15:0]     : completed blocks popped (only with CONV_PACKER_STATS_EN)
// Optional feature macro: CONV_PACKER_STATS_EN.
module conv_out_packer
    import conv_enc_pkg::*;
#(
    parameter int OBUF_DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  d_in,
    input  logic        d_valid,
    input  logic        blk_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic [1:0]  out_stream,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
`ifdef CONV_PACKER_STATS_EN
    ,
    output logic [15:0] blk_count
`endif
);

    pack_state_t                          state_reg;
    logic [2:0]                           fill_reg;
    logic [NUM_STREAMS-1:0][BYTE_W-1:0]   pack_reg;
    logic [NUM_STREAMS-1:0][BYTE_W-1:0]   pack_next;
    logic [NUM_STREAMS-1:0][BYTE_W-1:0]   hold_reg;
    logic                                 hold_last_reg;

    logic              accept;
    logic              flush;
    logic              emit_go;
    logic              obuf_full;
    logic              obuf_empty;
    logic              obuf_pop;
    logic [OBUF_W-1:0] obuf_wr;
    logic [OBUF_W-1:0] obuf_rd;
    logic [BYTE_W-1:0] emit_byte;

    // Gated by reset so the port reads 0 for the whole reset interval and
    // rises as soon as reset drops.
    assign in_ready = (state_reg == COLLECT) && !reset;
    assign accept   = d_valid && in_ready;
    // A blk_last symbol landing on bit 7 is one flush, never a second
    // all-padding one, because fill count and blk_last share this term.
    assign flush    = accept && ((fill_reg == 3'd7) || blk_last);

    // Each new symbol bit lands at position fill_reg; bits above it are still
    // zero, which gives the zero padding of early-flushed bytes for free.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STREAMS; gi++) begin : gen_pack
            assign pack_next[gi] = pack_reg[gi] | (BYTE_W'(d_in[gi]) << fill_reg);
        end
    endgenerate

    // An EMIT write may also proceed into a full FIFO when the consumer pops
    // in the same cycle.
    assign obuf_pop = out_valid && out_ready;
    assign emit_go  = (state_reg != COLLECT) && (!obuf_full || obuf_pop);

    always_comb begin
        emit_byte = hold_reg[0];
        case (state_reg)
            EMIT1:   emit_byte = hold_reg[1];
            EMIT2:   emit_byte = hold_reg[2];
            default: emit_byte = hold_reg[0];
        endcase
    end

    assign obuf_wr = {hold_last_reg && (state_reg == EMIT2), emit_stream(state_reg), emit_byte};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= COLLECT;
            fill_reg      <= '0;
            pack_reg      <= '0;
            hold_reg      <= '0;
            hold_last_reg <= 1'b0;
        end else begin
            if (accept) begin
                if (flush) begin
                    hold_reg      <= pack_next;
                    hold_last_reg <= blk_last;
                    pack_reg      <= '0;
                    fill_reg      <= '0;
                end else begin
                    pack_reg <= pack_next;
                    fill_reg <= fill_reg + 3'd1;
                end
            end
            case (state_reg)
                COLLECT: if (flush)   state_reg <= EMIT0;
                EMIT0:   if (emit_go) state_reg <= EMIT1;
                EMIT1:   if (emit_go) state_reg <= EMIT2;
                EMIT2:   if (emit_go) state_reg <= COLLECT;
                default:              state_reg <= COLLECT;
            endcase
        end
    end

    packer_obuf #(
        .DEPTH (OBUF_DEPTH),
        .WIDTH (OBUF_W)
    ) u_obuf (
        .clk     (clk),
        .reset   (reset),
        .push    (emit_go),
        .wr_data (obuf_wr),
        .pop     (obuf_pop),
        .rd_data (obuf_rd),
        .full    (obuf_full),
        .empty   (obuf_empty)
    );

    assign out_valid  = !obuf_empty;
    assign out_data   = obuf_rd[BYTE_W-1:0];
    assign out_stream = obuf_rd[BYTE_W+1:BYTE_W];
    assign out_last   = obuf_rd[BYTE_W+2];

`ifdef CONV_PACKER_STATS_EN
    logic [15:0] blk_count_reg;

    // Free-running 16-bit counter: wraps from 65535 to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_count_reg <= '0;
        end else if (obuf_pop && out_last) begin
            blk_count_reg <= blk_count_reg + 16'd1;
        end
    end

    assign blk_count = blk_count_reg;
`endif

endmodule
